bitmap_scan_encoder: RTL

//   Streaming multi-hit priority encoder.
//   - Accepts a RADIX-bit request bitmap over a valid/ready handshake.
//   - Emits the index of every set bit, one per accepted output beat, in priority order.
//   - Each beat also carries the matching one-hot vector and a last flag.
//   - Used between activation-sparsity masks and the PE dispatch queue to turn

---
 rtl/bitmap_scan_encoder.sv | 103 ++++++++++
 1 files changed

// File: rtl/bitmap_scan_encoder.sv
// Streaming multi-hit priority encoder: emits each set bit of an accepted bitmap as one beat.
// Optional macro BITMAP_SCAN_EMPTY_REPORT_EN: all-zero bitmaps emit one out_empty beat instead of being dropped.
module bitmap_scan_encoder #(
   parameter int RADIX     = 16,
   parameter int WIDTH     = $clog2(RADIX),
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [RADIX-1:0] in_bitmap,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_idx,
   output logic [RADIX-1:0] out_onehot,
   output logic             out_last,
   output logic             out_empty
);

   typedef enum logic {IDLE, SCAN} state_t;

   state_t            state;
   logic [RADIX-1:0]  pending;
   logic [WIDTH-1:0]  sel_idx;
   logic [RADIX-1:0]  sel_oh;
   logic              is_last;
   logic              beat;
   logic              accept;

   // Last assignment in the loop wins, so loop direction sets priority.
   always_comb begin
      sel_idx = '0;
      sel_oh  = '0;
      if (MSB_FIRST) begin
         for (int i = 0; i < RADIX; i++) begin
            if (pending[i]) begin
               sel_idx   = WIDTH'(i);
               sel_oh    = '0;
               sel_oh[i] = 1'b1;
            end
         end
      end else begin
         for (int i = RADIX-1; i >= 0; i--) begin
            if (pending[i]) begin
               sel_idx   = WIDTH'(i);
               sel_oh    = '0;
               sel_oh[i] = 1'b1;
            end
         end
      end
   end

   assign is_last    = (pending & (pending - RADIX'(1))) == '0;
   assign out_valid  = (state == SCAN);
   assign out_last   = out_valid & is_last;
   assign out_idx    = sel_idx;
   assign out_onehot = sel_oh;
   assign beat       = out_valid & out_ready;
   assign in_ready   = (state == IDLE) | (beat & is_last);
   assign accept     = in_valid & in_ready;

`ifdef BITMAP_SCAN_EMPTY_REPORT_EN
   logic empty_flag;

   assign out_empty = out_valid & empty_flag;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         pending    <= '0;
         empty_flag <= 1'b0;
      end else if (accept) begin
         state      <= SCAN;
         pending    <= in_bitmap;
         empty_flag <= (in_bitmap == '0);
      end else if (beat) begin
         pending <= pending & ~sel_oh;
         if (is_last) begin
            state      <= IDLE;
            empty_flag <= 1'b0;
         end
      end
   end
`else
   assign out_empty = 1'b0;

   // A zero bitmap is taken off the bus but never enters SCAN.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         pending <= '0;
      end else if (accept) begin
         state   <= (in_bitmap != '0) ? SCAN : IDLE;
         pending <= in_bitmap;
      end else if (beat) begin
         pending <= pending & ~sel_oh;
         if (is_last) state <= IDLE;
      end
   end
`endif

endmodule
